fifo_flush_sched: RTL and testbench

Read-side scheduler for the asymmetric 4-bit-in / 32-bit-out flushable FIFO. It issues `fifo_rd` pops whenever a full 32-bit word is available and the downstream can accept it. It also sequences `fifo_flush_req` on a software request or an inactivity timeout, and presents the FIFO's registered read data on a valid/ready stream through a 2-entry output buffer. It sits between the FIFO read port and the consumer.

---
 rtl/fifo_flush_sched.sv | 233 +++++++++++++++++++++++
 tb/tb_fifo_flush_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flush_sched.sv
// rtl/fifo_flush_sched.sv - read-side pop/flush scheduler with 2-entry output buffer
//
// Optional feature macro: FIFO_FLUSH_SCHED_TIMEOUT_EN
//   defined   : inactivity timeout counter raises automatic flushes
//   undefined : flushes come only from flush_start, TIMEOUT is ignored

module fifo_flush_sched #(
    parameter int TIMEOUT = 16,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_vld_rd_data,
    input  logic          fifo_empty,
    input  logic          fifo_flush_done,
    input  logic [DW-1:0] fifo_rd_data,
    output logic          fifo_rd,
    output logic          fifo_flush_req,
    input  logic          flush_start,
    output logic          flush_ack,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_data,
    output logic          out_flush,
    output logic          busy,
    output logic [15:0]   flush_cnt
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Output buffer: two entries, one-bit head/tail pointers
    logic [DW-1:0] buf_data [2];
    logic          buf_flag [2];
    logic          head;
    logic          tail;
    logic [1:0]    occ;

    // A pop issued last cycle whose data lands in the buffer this cycle
    logic          inflight;
    logic          inflight_flush;

    logic          flush_pend;
    logic          flush_pend_next;
    logic          timeout_hit;

    logic          out_fire;
    logic [2:0]    load;
    logic          credit;
    logic          req_now;
    logic          flush_pop;
    logic          done_hit;
    logic          drop_hit;

    assign out_fire = out_vld && out_rdy;

    // Words already committed downstream of the FIFO, net of the word leaving now
    assign load   = {1'b0, occ} + {2'b00, inflight} - {2'b00, out_fire};
    assign credit = (load < 3'd2);

    // A software pulse acts in the cycle it arrives; a timeout request waits in flush_pend
    assign req_now = flush_pend || flush_start;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_now && !fifo_empty) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fifo_flush_req && fifo_flush_done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: pop strobes and flush-completion events
    always_comb begin
        fifo_rd        = 1'b0;
        fifo_flush_req = 1'b0;
        drop_hit       = 1'b0;
        case (state)
            S_IDLE: begin
                // No normal read in the cycle a flush is being decided
                fifo_rd  = !req_now && fifo_vld_rd_data && credit;
                drop_hit = req_now && fifo_empty;
            end
            S_FLUSH: begin
                fifo_flush_req = credit;
            end
            default: begin
                fifo_rd        = 1'b0;
                fifo_flush_req = 1'b0;
            end
        endcase
    end

    // A flush request that meets an empty FIFO ends the flush instead of popping
    assign done_hit  = fifo_flush_req && fifo_flush_done;
    assign flush_pop = fifo_flush_req && !fifo_flush_done;

    assign busy = (state == S_FLUSH);

    // ------------------------------------------------------------------
    // Flush request tracking and timeout
    // ------------------------------------------------------------------

`ifdef FIFO_FLUSH_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] to_cnt;
    logic        to_run;

    assign to_run      = (state == S_IDLE) && !fifo_empty && !fifo_vld_rd_data && !flush_pend;
    assign timeout_hit = to_run && (to_cnt == TO_LAST);

    // Inactivity counter: runs only while a partial word sits untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 16'd0;
        end else if (to_run && !timeout_hit) begin
            to_cnt <= to_cnt + 16'd1;
        end else begin
            to_cnt <= 16'd0;
        end
    end
`else
    logic unused_timeout_param;

    assign unused_timeout_param = (TIMEOUT != 0);
    assign timeout_hit          = 1'b0;
`endif

    // Pending-flush next value; a coincident software pulse and timeout merge into one flush
    always_comb begin
        flush_pend_next = flush_pend;
        if ((state == S_IDLE) && req_now) begin
            flush_pend_next = 1'b0;
        end else if (done_hit) begin
            flush_pend_next = 1'b0;
        end else if (timeout_hit) begin
            flush_pend_next = 1'b1;
        end
    end

    // Pending flag, ack pulse and completed-flush counter
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
            flush_ack  <= 1'b0;
            flush_cnt  <= 16'd0;
        end else begin
            flush_pend <= flush_pend_next;
            flush_ack  <= drop_hit || done_hit;
            if (done_hit) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture path and output buffer
    // ------------------------------------------------------------------

    // Remember that a pop was issued so its data is captured next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight       <= 1'b0;
            inflight_flush <= 1'b0;
        end else begin
            inflight       <= fifo_rd || flush_pop;
            inflight_flush <= flush_pop;
        end
    end

    // Buffer storage: write at tail on capture
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_flag[0] <= 1'b0;
            buf_flag[1] <= 1'b0;
        end else if (inflight) begin
            buf_data[tail] <= fifo_rd_data;
            buf_flag[tail] <= inflight_flush;
        end
    end

    // Buffer pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= 1'b0;
            tail <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (inflight) begin
                tail <= ~tail;
            end
            if (out_fire) begin
                head <= ~head;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, out_fire};
        end
    end

    assign out_vld   = (occ != 2'd0);
    assign out_data  = buf_data[head];
    assign out_flush = buf_flag[head];

endmodule

// File: tb/tb_fifo_flush_sched.sv
// tb/tb_fifo_flush_sched.sv - self-checking bench for fifo_flush_sched

module tb_fifo_flush_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_vld_rd_data;
    logic        fifo_empty;
    logic        fifo_flush_done;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd;
    logic        fifo_flush_req;
    logic        flush_start;
    logic        flush_ack;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_data;
    logic        out_flush;
    logic        busy;
    logic [15:0] flush_cnt;

    fifo_flush_sched #(.TIMEOUT(4), .DW(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_vld_rd_data (fifo_vld_rd_data),
        .fifo_empty       (fifo_empty),
        .fifo_flush_done  (fifo_flush_done),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_rd          (fifo_rd),
        .fifo_flush_req   (fifo_flush_req),
        .flush_start      (flush_start),
        .flush_ack        (flush_ack),
        .out_vld          (out_vld),
        .out_rdy          (out_rdy),
        .out_data         (out_data),
        .out_flush        (out_flush),
        .busy             (busy),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    // Cycle number, valid between one rising edge and the next
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit-in / 32-bit-out flushable FIFO, first nibble in the LSBs
    logic [3:0]  mq [$];
    int          level = 0;
    int          wr_n;
    logic [3:0]  wr_base;
    logic [31:0] rd_data_q = '0;

    function automatic logic [31:0] pop_word();
        int          k = (mq.size() < 8) ? mq.size() : 8;
        logic [31:0] w = '0;
        for (int i = 0; i < k; i++) w[4*i +: 4] = mq.pop_front();
        return w;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            level     <= 0;
            rd_data_q <= '0;
        end else begin
            if (fifo_rd || (fifo_flush_req && mq.size() != 0)) rd_data_q <= pop_word();
            for (int i = 0; i < wr_n; i++) mq.push_back(4'(int'(wr_base) + i));
            level <= mq.size();
        end
    end

    assign fifo_vld_rd_data = (level >= 8);
    assign fifo_empty       = (level == 0);
    assign fifo_flush_done  = fifo_flush_req && fifo_empty;
    assign fifo_rd_data     = rd_data_q;

    // Observation of pops, delivered words and acks, sampled mid-cycle
    int          npops = 0;
    int          nacks = 0;
    int          both_err = 0;
    int          max_out = 0;
    int          last_pop_cyc = 0;
    int          last_fpop_cyc = 0;
    int          last_rise_cyc = 0;
    int          last_ack_cyc = 0;
    logic        prev_vld = 1'b0;
    logic [31:0] got_w [$];
    logic        got_t [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (npops - got_w.size() > max_out) max_out <= npops - got_w.size();
            npops <= npops + int'(fifo_rd) + int'(fifo_flush_req && !fifo_flush_done);
            if (fifo_rd || (fifo_flush_req && !fifo_flush_done)) last_pop_cyc <= cyc;
            if (fifo_flush_req && !fifo_flush_done) last_fpop_cyc <= cyc;
            if (fifo_rd && fifo_flush_req) both_err <= both_err + 1;
            if (out_vld && out_rdy) begin
                got_w.push_back(out_data);
                got_t.push_back(out_flush);
            end
            if (out_vld && !prev_vld) last_rise_cyc <= cyc;
            prev_vld <= out_vld;
            if (flush_ack) begin
                nacks        <= nacks + 1;
                last_ack_cyc <= cyc;
            end
        end else begin
            prev_vld <= 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input int idx);
        return (idx < got_w.size()) ? got_w[idx] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic tag_at(input int idx);
        return (idx < got_t.size()) ? got_t[idx] : 1'bx;
    endfunction

    typedef struct {
        int          n_nib;
        logic [3:0]  first;
        bit          do_flush;
        bit          exp_busy1;
        int          exp_words;
        logic [31:0] w0;
        bit          t0;
        logic [31:0] w1;
        bit          t1;
        int          exp_acks;
        int          exp_inc;
        bit          chk_lat;
        bit          chk_ack_lat;
    } vec_t;

    vec_t vecs [5];

    int b_pops, b_words, b_acks, w_cyc, fs_cyc;
    logic [15:0] b_cnt;

    initial begin
        // {nibbles, first, flush, busy+req after pulse, words, w0, t0, w1, t1, acks, cnt+, lat, acklat}
        vecs[0] = '{8,  4'h1, 0, 0, 1, 32'h8765_4321, 0, 32'h0,         0, 0, 0, 1, 0};
        vecs[1] = '{3,  4'hA, 1, 1, 1, 32'h0000_0CBA, 1, 32'h0,         0, 1, 1, 0, 0};
        vecs[2] = '{16, 4'h0, 0, 0, 2, 32'h7654_3210, 0, 32'hFEDC_BA98, 0, 0, 0, 0, 0};
        vecs[3] = '{0,  4'h0, 1, 0, 0, 32'h0,         0, 32'h0,         0, 1, 0, 0, 1};
        vecs[4] = '{10, 4'h1, 1, 1, 2, 32'h8765_4321, 0, 32'h0000_00A9, 1, 1, 1, 0, 0};

        rst = 1'b1; wr_n = 0; wr_base = '0; flush_start = 1'b0; out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst fifo_rd",        32'(fifo_rd),        32'd0);
        check("rst fifo_flush_req", 32'(fifo_flush_req), 32'd0);
        check("rst out_vld",        32'(out_vld),        32'd0);
        check("rst out_data",       out_data,            32'd0);
        check("rst out_flush",      32'(out_flush),      32'd0);
        check("rst flush_ack",      32'(flush_ack),      32'd0);
        check("rst busy",           32'(busy),           32'd0);
        check("rst flush_cnt",      32'(flush_cnt),      32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Table-driven single-scenario vectors, consumer always ready
        for (int v = 0; v < 5; v++) begin
            b_pops = npops; b_words = got_w.size(); b_acks = nacks; b_cnt = flush_cnt;
            tick(); wr_n = vecs[v].n_nib; wr_base = vecs[v].first; w_cyc = cyc;
            tick(); wr_n = 0;
            tick();
            tick();
            if (vecs[v].do_flush) begin
                flush_start = 1'b1;
                fs_cyc = cyc;
            end
            tick(); flush_start = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d busy after flush_start", v), 32'(busy), 32'(vecs[v].exp_busy1));
            check($sformatf("v%0d flush_req after flush_start", v), 32'(fifo_flush_req), 32'(vecs[v].exp_busy1));
            repeat (30) tick();
            @(negedge clk);
            check($sformatf("v%0d pops", v),   32'(npops - b_pops),         32'(vecs[v].exp_words));
            check($sformatf("v%0d words", v),  32'(got_w.size() - b_words), 32'(vecs[v].exp_words));
            if (vecs[v].exp_words > 0) begin
                check($sformatf("v%0d word0", v), word_at(b_words),      vecs[v].w0);
                check($sformatf("v%0d tag0", v),  32'(tag_at(b_words)),  32'(vecs[v].t0));
            end
            if (vecs[v].exp_words > 1) begin
                check($sformatf("v%0d word1", v), word_at(b_words + 1),     vecs[v].w1);
                check($sformatf("v%0d tag1", v),  32'(tag_at(b_words + 1)), 32'(vecs[v].t1));
            end
            check($sformatf("v%0d acks", v),      32'(nacks - b_acks),       32'(vecs[v].exp_acks));
            check($sformatf("v%0d flush_cnt", v), 32'(flush_cnt - b_cnt),    32'(vecs[v].exp_inc));
            check($sformatf("v%0d busy end", v),  32'(busy),                 32'd0);
            if (vecs[v].chk_lat)
                check("pop to out_vld latency", 32'(last_rise_cyc - last_pop_cyc), 32'd2);
            if (vecs[v].chk_ack_lat)
                check("empty flush ack latency", 32'(last_ack_cyc - fs_cyc), 32'd1);
        end

        // Stalled consumer: credit limits pops to two, then drain with a trailing flush word
        b_pops = npops; b_words = got_w.size(); b_acks = nacks; b_cnt = flush_cnt;
        tick(); out_rdy = 1'b0; wr_n = 20; wr_base = 4'h0;
        tick(); wr_n = 0;
        repeat (2) tick();
        tick(); flush_start = 1'b1;
        tick(); flush_start = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("stall pops",      32'(npops - b_pops), 32'd2);
        check("stall busy",      32'(busy),           32'd1);
        check("stall out_vld",   32'(out_vld),        32'd1);
        check("stall head data", out_data,            32'h7654_3210);
        check("stall head tag",  32'(out_flush),      32'd0);
        tick(); out_rdy = 1'b1;
        repeat (30) tick();
        @(negedge clk);
        check("drain words",     32'(got_w.size() - b_words), 32'd3);
        check("drain word0",     word_at(b_words),            32'h7654_3210);
        check("drain tag0",      32'(tag_at(b_words)),        32'd0);
        check("drain word1",     word_at(b_words + 1),        32'hFEDC_BA98);
        check("drain tag1",      32'(tag_at(b_words + 1)),    32'd0);
        check("drain word2",     word_at(b_words + 2),        32'h0000_3210);
        check("drain tag2",      32'(tag_at(b_words + 2)),    32'd1);
        check("drain flush_cnt", 32'(flush_cnt - b_cnt),      32'd1);
        check("drain acks",      32'(nacks - b_acks),         32'd1);

        // Partial word left idle
        b_pops = npops; b_words = got_w.size(); b_cnt = flush_cnt;
        tick(); wr_n = 2; wr_base = 4'h5; w_cyc = cyc;
        tick(); wr_n = 0;
`ifdef FIFO_FLUSH_SCHED_TIMEOUT_EN
        repeat (30) tick();
        @(negedge clk);
        check("timeout words",     32'(got_w.size() - b_words),  32'd1);
        check("timeout word",      word_at(b_words),             32'h0000_0065);
        check("timeout tag",       32'(tag_at(b_words)),         32'd1);
        check("timeout req cycle", 32'(last_fpop_cyc - w_cyc),   32'd6);
        check("timeout flush_cnt", 32'(flush_cnt - b_cnt),       32'd1);
`else
        repeat (100) tick();
        @(negedge clk);
        check("no timeout pops",  32'(npops - b_pops),         32'd0);
        check("no timeout words", 32'(got_w.size() - b_words), 32'd0);
        check("no timeout busy",  32'(busy),                   32'd0);
        tick(); flush_start = 1'b1;
        tick(); flush_start = 1'b0;
        repeat (20) tick();
        @(negedge clk);
        check("manual partial word", word_at(b_words),        32'h0000_0065);
        check("manual partial tag",  32'(tag_at(b_words)),    32'd1);
        check("manual flush_cnt",    32'(flush_cnt - b_cnt),  32'd1);
`endif

        check("rd and flush_req overlap", 32'(both_err), 32'd0);
        check("max outstanding words",    32'(max_out > 2), 32'd0);

        // Reset in the middle of a stalled flush with two words buffered
        tick(); out_rdy = 1'b0; wr_n = 20; wr_base = 4'h3;
        tick(); wr_n = 0;
        repeat (2) tick();
        tick(); flush_start = 1'b1;
        tick(); flush_start = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        check("pre-reset busy",    32'(busy),    32'd1);
        check("pre-reset out_vld", 32'(out_vld), 32'd1);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        check("post-reset out_vld",   32'(out_vld),        32'd0);
        check("post-reset busy",      32'(busy),           32'd0);
        check("post-reset flush_cnt", 32'(flush_cnt),      32'd0);
        check("post-reset fifo_rd",   32'(fifo_rd),        32'd0);
        check("post-reset flush_req", 32'(fifo_flush_req), 32'd0);
        check("post-reset out_data",  out_data,            32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
